// File: rtl/dvlsi_arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding for the bit-serial units
// and the full-subtractor truth functions used by serial and ripple datapaths.
package dvlsi_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic fs_diff(input logic x, input logic y, input logic bi);
      return x ^ y ^ bi;
   endfunction

   // Borrow out when the minuend bit cannot cover subtrahend plus incoming borrow.
   function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
      return (~x & y) | (~(x ^ y) & bi);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Controller-facing handshake and operand/result bundle of the serial subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_subtractor_fs.sv
// Combinational one-bit full subtractor; shared cell for serial and ripple subtractors.
module full_subtractor
   import dvlsi_arith_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = fs_diff(x, y, bi);
   assign bo = fs_borrow(x, y, bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b - bin LSB first through one full-subtractor
// cell and a borrow flop, with a start/busy/done handshake.
module serial_subtractor
   import dvlsi_arith_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   serial_subtractor_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] diff_q;
   logic             br;
   logic             bout_q;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             bo_bit;
   logic             last_bit;

   full_subtractor u_fs (
      .x  (ra[0]),
      .y  (rb[0]),
      .bi (br),
      .d  (d_bit),
      .bo (bo_bit)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (bus.start) state_nx = ST_SHIFT;
         ST_SHIFT: if (last_bit)  state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Operands are only sampled on an accepted start, so bus changes while busy are harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra     <= '0;
         rb     <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  ra  <= bus.a;
                  rb  <= bus.b;
                  br  <= bus.bin;
                  cnt <= '0;
               end
            end
            ST_SHIFT: begin
               diff_q <= {d_bit, diff_q[WIDTH-1:1]};
               ra     <= ra >> 1;
               rb     <= rb >> 1;
               br     <= bo_bit;
               if (!last_bit) cnt <= cnt + CW'(1);
            end
            ST_DONE: begin
               bout_q <= br;
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

   // The final borrow is exposed straight from the flop during DONE, then held.
   assign bus.busy = (state != ST_IDLE);
   assign bus.done = (state == ST_DONE);
   assign bus.diff = diff_q;
   assign bus.bout = (state == ST_DONE) ? br : bout_q;

endmodule
